// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and FSM encodings for the multi-port register file.
package regfile_mp_sb_pkg;
  localparam int RF_XLEN_DEF = 64;
  localparam int RF_NREG_DEF = 32;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/regfile_mp_sb_busy_table.sv
// Per-register pending-producer bits; a same-cycle issue beats a writeback clear.
module rf_busy_table #(
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);
  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w]) busy_d[wr_addr[w*AW +: AW]] = 1'b0;
    if (iss_en) busy_d[iss_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) rd_busy[p] = busy_q[rd_addr[p*AW +: AW]];
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: post-reset clear walk, write-port priority merge,
// optional same-cycle bypass, busy scoreboard and a write-through debug view.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter  int XLEN   = RF_XLEN_DEF,
  parameter  int NREG   = RF_NREG_DEF,
  parameter  int NRD    = 2,
  parameter  int NWR    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 ready,
  output logic [NREG*XLEN-1:0] dbg_regs
);
  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            run, iss_vld;
  logic [NWR-1:0]  wr_vld;
  logic [NREG-1:0] hit;
  logic [XLEN-1:0] hit_data [NREG];
  logic [AW-1:0]   ra [NRD];
  logic [NRD-1:0]  raw_busy;

  assign run     = (state_q == ST_RUN);
  assign ready   = run;
  assign iss_vld = run && iss_en && (iss_addr != '0);

  always_comb begin
    wr_vld = '0;
    for (int w = 0; w < NWR; w++)
      wr_vld[w] = run && wr_en[w] && (wr_addr[w*AW +: AW] != '0);
  end

  // Later ports overwrite earlier ones, so the highest-index writer wins.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NREG; i++) begin
      hit_data[i] = '0;
      for (int w = 0; w < NWR; w++)
        if (wr_vld[w] && (wr_addr[w*AW +: AW] == AW'(i))) begin
          hit[i]      = 1'b1;
          hit_data[i] = wr_data[w*XLEN +: XLEN];
        end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (run) begin
      for (int i = 0; i < NREG; i++)
        if (hit[i]) regs_d[i] = hit_data[i];
    end else begin
      regs_d[clr_idx_q] = '0;
      clr_idx_d         = clr_idx_q + AW'(1);
      if (clr_idx_q == AW'(NREG-1)) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Data array has no reset: the clear walk zeroes it before ports go live.
  always_ff @(posedge clk) begin
    if (!rst) regs_q <= regs_d;
  end

  rf_busy_table #(.NREG(NREG), .NRD(NRD), .NWR(NWR)) u_busy (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_vld),
    .iss_addr (iss_addr),
    .wr_en    (wr_vld),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (raw_busy)
  );

  always_comb begin
    for (int p = 0; p < NRD; p++) ra[p] = rd_addr[p*AW +: AW];
  end

  // A bypassed write retires the producer unless a new one issues to the same reg.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++)
      if (run && rd_en[p] && (ra[p] != '0)) begin
        rd_data[p*XLEN +: XLEN] = ((BYPASS != 0) && hit[ra[p]]) ? hit_data[ra[p]] : regs_q[ra[p]];
        rd_busy[p] = raw_busy[p] &&
                     !((BYPASS != 0) && hit[ra[p]] && !(iss_vld && (iss_addr == ra[p])));
      end
  end

  always_comb begin
    dbg_regs = '0;
    for (int i = 1; i < NREG; i++)
      dbg_regs[i*XLEN +: XLEN] = hit[i] ? hit_data[i] : regs_q[i];
  end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (default build) plus a 16-reg/4-read/3-write
// no-bypass build exercised against a small reference model.
module tb_regfile_mp_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance: XLEN=64, NREG=32, NRD=2, NWR=2, BYPASS=1
  logic [1:0]       rd_en;
  logic [9:0]       rd_addr;
  logic [127:0]     rd_data;
  logic [1:0]       rd_busy;
  logic [1:0]       wr_en;
  logic [9:0]       wr_addr;
  logic [127:0]     wr_data;
  logic             iss_en;
  logic [4:0]       iss_addr;
  logic             ready;
  logic [2047:0]    dbg;

  // Second instance: NREG=16, NRD=4, NWR=3, BYPASS=0
  logic [3:0]       rd_en2;
  logic [15:0]      rd_addr2;
  logic [255:0]     rd_data2;
  logic [3:0]       rd_busy2;
  logic [2:0]       wr_en2;
  logic [11:0]      wr_addr2;
  logic [191:0]     wr_data2;
  logic             iss_en2;
  logic [3:0]       iss_addr2;
  logic             ready2;
  logic [1023:0]    dbg2;

  regfile_mp_sb dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .ready(ready), .dbg_regs(dbg)
  );

  regfile_mp_sb #(.XLEN(64), .NREG(16), .NRD(4), .NWR(3), .BYPASS(0)) dut2 (
    .clk(clk), .rst(rst), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .rd_busy(rd_busy2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .iss_en(iss_en2), .iss_addr(iss_addr2), .ready(ready2), .dbg_regs(dbg2)
  );

  int checks   = 0;
  int failures = 0;
  int lo;
  logic [63:0] m2 [16];
  logic [15:0] mb2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic idle;
    rd_en  = '0; rd_addr  = '0; wr_en  = '0; wr_addr  = '0; wr_data  = '0; iss_en  = 1'b0; iss_addr  = '0;
    rd_en2 = '0; rd_addr2 = '0; wr_en2 = '0; wr_addr2 = '0; wr_data2 = '0; iss_en2 = 1'b0; iss_addr2 = '0;
  endtask

  function automatic logic [63:0] garb(input int i);
    return 64'hDEADBEEF_00000000 | 64'(i);
  endfunction

  initial begin
    idle();
    rst = 1'b1; tick; tick; rst = 1'b0;

    // Initial walk
    rd_en = 2'b11; rd_addr = {5'd9, 5'd5};
    settle;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rd0", rd_data[63:0], 64'd0);
    chk("rst_busy", 64'(rd_busy), 64'd0);
    lo = 0;
    while (!ready && lo < 100) begin lo++; tick; end
    chk("walk_len0", 64'(lo), 64'd32);

    // Fill with garbage
    rd_en = '0;
    for (int i = 1; i < 32; i += 2) begin
      wr_en   = 2'b11;
      wr_addr = {5'(i + 1), 5'(i)};
      wr_data = {garb(i + 1), garb(i)};
      tick;
    end
    wr_en = '0;
    rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
    settle;
    chk("garb_rd0", rd_data[63:0], garb(5));
    chk("garb_rd1", rd_data[127:64], garb(31));
    chk("garb_dbg31", dbg[31*64 +: 64], garb(31));

    // Reset over live contents; issue during INIT must be ignored
    rst = 1'b1; tick; rst = 1'b0;
    iss_en = 1'b1; iss_addr = 5'd9;
    settle;
    chk("init_ready", 64'(ready), 64'd0);
    chk("init_rd0", rd_data[63:0], 64'd0);
    chk("init_rd1", rd_data[127:64], 64'd0);
    chk("init_busy", 64'(rd_busy), 64'd0);
    chk("init_dbg5", dbg[5*64 +: 64], garb(5));
    lo = 0;
    while (!ready && lo < 100) begin lo++; tick; iss_en = 1'b0; end
    chk("walk_len1", 64'(lo), 64'd32);
    settle;
    for (int i = 0; i < 32; i++) chk($sformatf("dbg_clr%0d", i), dbg[i*64 +: 64], 64'd0);
    rd_addr = {5'd9, 5'd5};
    settle;
    chk("init_iss_ign", 64'(rd_busy[1]), 64'd0);
    chk("walk2_ready", 64'(ready2), 64'd1);

    // Reset mid-walk at clr_idx=10
    rst = 1'b1; tick; rst = 1'b0;
    repeat (10) tick;
    settle;
    chk("mid_ready", 64'(ready), 64'd0);
    rst = 1'b1; tick; rst = 1'b0;
    lo = 0;
    while (!ready && lo < 100) begin lo++; tick; end
    chk("walk_len_mid", 64'(lo), 64'd32);

    // Write-port conflict, bypass vs. no bypass
    idle();
    wr_en  = 2'b11;  wr_addr  = {5'd5, 5'd5};       wr_data  = {64'h5555, 64'hAAAA};
    wr_en2 = 3'b011; wr_addr2 = {4'd0, 4'd5, 4'd5}; wr_data2 = {64'd0, 64'h5555, 64'hAAAA};
    rd_en  = 2'b01;  rd_addr  = {5'd0, 5'd5};
    rd_en2 = 4'b0001; rd_addr2 = {12'd0, 4'd5};
    settle;
    chk("conf_byp_rd", rd_data[63:0], 64'h5555);
    chk("conf_dbg5", dbg[5*64 +: 64], 64'h5555);
    chk("conf_nobyp_rd", rd_data2[63:0], 64'd0);
    chk("conf_nobyp_dbg5", dbg2[5*64 +: 64], 64'h5555);
    tick;
    wr_en = '0; wr_en2 = '0;
    settle;
    chk("conf_rd_next", rd_data[63:0], 64'h5555);
    chk("conf_rd2_next", rd_data2[63:0], 64'h5555);

    // x0 is hardwired
    idle();
    wr_en = 2'b01; wr_addr = '0; wr_data = {64'd0, 64'hFFFF};
    iss_en = 1'b1; iss_addr = 5'd0;
    rd_en = 2'b11; rd_addr = '0;
    settle;
    chk("x0_rd", rd_data[63:0], 64'd0);
    chk("x0_busy", 64'(rd_busy), 64'd0);
    chk("x0_dbg", dbg[63:0], 64'd0);
    tick;
    wr_en = '0; iss_en = 1'b0;
    settle;
    chk("x0_rd_next", rd_data[63:0], 64'd0);
    chk("x0_busy_next", 64'(rd_busy), 64'd0);

    // Scoreboard
    idle();
    iss_en = 1'b1; iss_addr = 5'd7;
    rd_en = 2'b01; rd_addr = {5'd7, 5'd7};
    settle;
    chk("sb_iss_same", 64'(rd_busy[0]), 64'd0);
    tick;
    iss_en = 1'b0;
    settle;
    chk("sb_set", 64'(rd_busy[0]), 64'd1);
    chk("sb_rden0_busy", 64'(rd_busy[1]), 64'd0);
    chk("sb_rden0_data", rd_data[127:64], 64'd0);
    iss_en = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {64'd0, 64'h77};
    settle;
    chk("sb_isswr_same", 64'(rd_busy[0]), 64'd1);
    chk("sb_isswr_rd", rd_data[63:0], 64'h77);
    tick;
    iss_en = 1'b0; wr_en = '0;
    settle;
    chk("sb_stay", 64'(rd_busy[0]), 64'd1);
    chk("sb_stay_rd", rd_data[63:0], 64'h77);
    wr_en = 2'b01; wr_data = {64'd0, 64'h88};
    settle;
    chk("sb_wr_byp", 64'(rd_busy[0]), 64'd0);
    chk("sb_wr_rd", rd_data[63:0], 64'h88);
    tick;
    wr_en = '0;
    settle;
    chk("sb_clr", 64'(rd_busy[0]), 64'd0);

    // Random traffic on the 16-reg no-bypass build
    idle();
    rst = 1'b1; tick; rst = 1'b0;
    lo = 0;
    while (!ready2 && lo < 100) begin lo++; tick; end
    chk("walk_len2", 64'(lo), 64'd16);
    for (int i = 0; i < 16; i++) m2[i] = '0;
    mb2 = '0;
    for (int c = 0; c < 10000; c++) begin
      int j;
      rd_en2    = 4'($urandom);
      rd_addr2  = 16'($urandom);
      wr_en2    = 3'($urandom);
      wr_addr2  = 12'($urandom);
      wr_data2  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      iss_en2   = 1'($urandom);
      iss_addr2 = 4'($urandom);
      settle;
      for (int p = 0; p < 4; p++) begin
        logic [3:0] a;
        a = rd_addr2[p*4 +: 4];
        chk("rnd_rd", rd_data2[p*64 +: 64], (rd_en2[p] && a != 4'd0) ? m2[a] : 64'd0);
        chk("rnd_busy", 64'(rd_busy2[p]), (rd_en2[p] && a != 4'd0) ? 64'(mb2[a]) : 64'd0);
      end
      for (int w = 0; w < 3; w++)
        if (wr_en2[w] && wr_addr2[w*4 +: 4] != 4'd0) begin
          m2[wr_addr2[w*4 +: 4]]  = wr_data2[w*64 +: 64];
          mb2[wr_addr2[w*4 +: 4]] = 1'b0;
        end
      if (iss_en2 && iss_addr2 != 4'd0) mb2[iss_addr2] = 1'b1;
      j = $urandom_range(0, 15);
      chk("rnd_dbg", dbg2[j*64 +: 64], (j == 0) ? 64'd0 : m2[j]);
      tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
